// File: rtl/dmem_lsu.sv
// Load/store unit between the single-cycle MIPS datapath and a word-wide dmem.
// Sub-word loads are extracted combinationally; sub-word stores use a two-cycle read-modify-write.
module dmem_lsu #(
  parameter int BIG_ENDIAN = 0,
  parameter int ERRCNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req,
  input  logic                wr,
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                stall,
  output logic                misalign,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic                mem_wr,
  output logic [29:0]         mem_addr,
  output logic [31:0]         mem_writedata,
  input  logic [31:0]         mem_readdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      state_q, state_d;
  logic        capture;
  logic        misaligned;
  logic [31:0] cap_word_p0;
  logic [31:0] cap_addr_p0;
  logic [15:0] cap_wdata_p0;
  logic [1:0]  cap_size_p0;

  // Byte lane (0 = bits 7:0) addressed by a[1:0], mirrored for big-endian.
  function automatic logic [1:0] byte_lane(input logic [1:0] a);
    return (BIG_ENDIAN != 0) ? ~a : a;
  endfunction

  // 1 selects bits 31:16.
  function automatic logic half_lane(input logic a1);
    return (BIG_ENDIAN != 0) ? ~a1 : a1;
  endfunction

  function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic sx);
    logic signed [7:0]  sb;
    logic signed [31:0] sw;
    sb = signed'(b);
    sw = sb;
    return sx ? unsigned'(sw) : {24'd0, b};
  endfunction

  function automatic logic [31:0] extend_half(input logic [15:0] h, input logic sx);
    logic signed [15:0] sh;
    logic signed [31:0] sw;
    sh = signed'(h);
    sw = sh;
    return sx ? unsigned'(sw) : {16'd0, h};
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] a,
                                          input logic [1:0] sz, input logic sx);
    logic [31:0] shifted;
    shifted = word;
    case (sz)
      SZ_BYTE: begin
        shifted = word >> {byte_lane(a), 3'b000};
        return extend_byte(shifted[7:0], sx);
      end
      SZ_HALF: begin
        shifted = word >> {half_lane(a[1]), 4'b0000};
        return extend_half(shifted[15:0], sx);
      end
      default: return shifted;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] a,
                                        input logic [1:0] sz, input logic [15:0] d);
    logic [31:0] mask;
    logic [31:0] ins;
    if (sz == SZ_BYTE) begin
      mask = 32'h0000_00FF << {byte_lane(a), 3'b000};
      ins  = {24'd0, d[7:0]} << {byte_lane(a), 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {half_lane(a[1]), 4'b0000};
      ins  = {16'd0, d} << {half_lane(a[1]), 4'b0000};
    end
    return (word & ~mask) | (ins & mask);
  endfunction

  always_comb begin
    case (size)
      SZ_HALF: misaligned = addr[0];
      SZ_WORD: misaligned = (addr[1:0] != 2'b00);
      SZ_BYTE: misaligned = 1'b0;
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    rdata         = 32'd0;
    stall         = 1'b0;
    misalign      = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = addr[31:2];
    mem_writedata = wdata;
    capture       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (misaligned) begin
            misalign = 1'b1;
          end else if (!wr) begin
            rdata = extract(mem_readdata, addr[1:0], size, sign_ext);
          end else if (size == SZ_WORD) begin
            mem_wr = 1'b1;
          end else begin
            stall   = 1'b1;
            capture = 1'b1;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        mem_addr      = cap_addr_p0[31:2];
        mem_writedata = merge(cap_word_p0, cap_addr_p0[1:0], cap_size_p0, cap_wdata_p0);
        mem_wr        = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are quiet for as long as reset is held, whatever the CPU drives.
    if (!reset_n) begin
      rdata    = 32'd0;
      stall    = 1'b0;
      misalign = 1'b0;
      mem_wr   = 1'b0;
      capture  = 1'b0;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      err_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (misalign && (err_cnt != {ERRCNT_W{1'b1}}))
        err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end

  // p0: read half of the read-modify-write, consumed in WRITE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_word_p0  <= 32'd0;
      cap_addr_p0  <= 32'd0;
      cap_wdata_p0 <= 16'd0;
      cap_size_p0  <= 2'd0;
    end else if (capture) begin
      cap_word_p0  <= mem_readdata;
      cap_addr_p0  <= addr;
      cap_wdata_p0 <= wdata[15:0];
      cap_size_p0  <= size;
    end
  end

endmodule
